// File: rtl/dp_bsram_param.sv
// Parametrised true dual-port block RAM: byte-lane writes, selectable write and read modes, collision flag.
// Optional power-up clear sweep enabled by defining DP_BSRAM_INIT_CLEAR_EN.
module dp_bsram_param #(
  parameter int A_SIZE     = 10,
  parameter int DEPTH      = 1024,
  parameter int W_SIZE     = 16,
  parameter int WRITE_MODE = 0,
  parameter int READ_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cea,
  input  logic                  ceb,
  input  logic                  ocea,
  input  logic                  oceb,
  input  logic                  wra,
  input  logic                  wrb,
  input  logic [W_SIZE/8-1:0]   bea,
  input  logic [W_SIZE/8-1:0]   beb,
  input  logic [A_SIZE-1:0]     addra,
  input  logic [A_SIZE-1:0]     addrb,
  input  logic [W_SIZE-1:0]     dina,
  input  logic [W_SIZE-1:0]     dinb,
  output logic [W_SIZE-1:0]     douta,
  output logic [W_SIZE-1:0]     doutb,
  output logic                  collision,
  output logic                  busy
);

  localparam int NB = W_SIZE / 8;
  localparam logic [A_SIZE:0] DEPTH_W = (A_SIZE + 1)'(DEPTH);

  logic [W_SIZE-1:0] mem [DEPTH];
  logic [W_SIZE-1:0] ra, rb;
  logic [W_SIZE-1:0] old_a, old_b;
  logic              in_a, in_b;
  logic              we_a, we_b;

  function automatic logic [W_SIZE-1:0] merge_lanes(input logic [W_SIZE-1:0] old_w,
                                                    input logic [W_SIZE-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    merge_lanes = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merge_lanes[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Optional clear sweep
  // ---------------------------------------------------------------------------
`ifdef DP_BSRAM_INIT_CLEAR_EN
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [A_SIZE-1:0] LAST_ADDR = A_SIZE'(DEPTH - 1);

  state_t            state, state_nx;
  logic [A_SIZE-1:0] ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) ptr <= ptr + 1'b1;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    if (state == CLEAR && ptr == LAST_ADDR) state_nx = IDLE;
  end

  always_comb begin
    busy = (state == CLEAR);
  end
`else
  assign busy = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Address decode and array access
  // ---------------------------------------------------------------------------
  always_comb begin
    in_a  = ({1'b0, addra} < DEPTH_W);
    in_b  = ({1'b0, addrb} < DEPTH_W);
    old_a = in_a ? mem[addra] : '0;
    old_b = in_b ? mem[addrb] : '0;
    we_a  = cea && wra && in_a && !reset && !busy;
    we_b  = ceb && wrb && in_b && !reset && !busy;
  end

  // NOTE: the array has no reset; contents survive reset, which also keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
`ifdef DP_BSRAM_INIT_CLEAR_EN
    if (busy && !reset) mem[ptr] <= '0;
`endif
    // Port A is written after port B so it wins on shared lanes of a shared address.
    for (int i = 0; i < NB; i++) begin
      if (we_b && beb[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
      if (we_a && bea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Read registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || busy) begin
      ra <= '0;
    end else if (cea) begin
      if (!wra) begin
        ra <= old_a;
      end else begin
        case (WRITE_MODE)
          1:       ra <= in_a ? merge_lanes(old_a, dina, bea) : '0;
          2:       ra <= old_a;
          default: ra <= ra;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || busy) begin
      rb <= '0;
    end else if (ceb) begin
      if (!wrb) begin
        rb <= old_b;
      end else begin
        case (WRITE_MODE)
          1:       rb <= in_b ? merge_lanes(old_b, dinb, beb) : '0;
          2:       rb <= old_b;
          default: rb <= rb;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  generate
    if (READ_MODE == 1) begin : g_pipe
      logic [W_SIZE-1:0] oa, ob;

      always_ff @(posedge clk) begin
        if (reset) begin
          oa <= '0;
          ob <= '0;
        end else begin
          if (ocea) oa <= ra;
          if (oceb) ob <= rb;
        end
      end

      assign douta = oa;
      assign doutb = ob;
    end else begin : g_bypass
      logic unused_oce;
      assign unused_oce = ocea ^ oceb;
      assign douta      = ra;
      assign doutb      = rb;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Collision flag: registered, so it reports the previous edge's access pair
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      collision <= 1'b0;
    end else begin
      collision <= cea && ceb && in_a && in_b && (addra == addrb) && (wra || wrb) && !busy;
    end
  end

endmodule

// File: tb/tb_dp_bsram_param.sv
// Directed bench for dp_bsram_param: five instances share stimulus to cover write modes, read pipeline and depth.
// Clear-sweep checks are compiled in when DP_BSRAM_INIT_CLEAR_EN is defined.
module tb_dp_bsram_param;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        cea, ceb, ocea, oceb, wra, wrb;
  logic [1:0]  bea, beb;
  logic [9:0]  addra, addrb;
  logic [15:0] dina, dinb;

  logic [15:0] douta_w [N];
  logic [15:0] doutb_w [N];
  logic        col_w   [N];
  logic        busy_w  [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 0: default, 1: write-through, 2: read-before-write, 3: pipelined output, 4: DEPTH=1000
  dp_bsram_param #(.WRITE_MODE(0), .READ_MODE(0), .DEPTH(1024)) u0 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb), .wra(wra), .wrb(wrb),
    .bea(bea), .beb(beb), .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta_w[0]), .doutb(doutb_w[0]), .collision(col_w[0]), .busy(busy_w[0]));
  dp_bsram_param #(.WRITE_MODE(1), .READ_MODE(0), .DEPTH(1024)) u1 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb), .wra(wra), .wrb(wrb),
    .bea(bea), .beb(beb), .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta_w[1]), .doutb(doutb_w[1]), .collision(col_w[1]), .busy(busy_w[1]));
  dp_bsram_param #(.WRITE_MODE(2), .READ_MODE(0), .DEPTH(1024)) u2 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb), .wra(wra), .wrb(wrb),
    .bea(bea), .beb(beb), .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta_w[2]), .doutb(doutb_w[2]), .collision(col_w[2]), .busy(busy_w[2]));
  dp_bsram_param #(.WRITE_MODE(0), .READ_MODE(1), .DEPTH(1024)) u3 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb), .wra(wra), .wrb(wrb),
    .bea(bea), .beb(beb), .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta_w[3]), .doutb(doutb_w[3]), .collision(col_w[3]), .busy(busy_w[3]));
  dp_bsram_param #(.WRITE_MODE(0), .READ_MODE(0), .DEPTH(1000)) u4 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb), .wra(wra), .wrb(wrb),
    .bea(bea), .beb(beb), .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta_w[4]), .doutb(doutb_w[4]), .collision(col_w[4]), .busy(busy_w[4]));

  typedef struct {
    logic        cea, wra;
    logic [1:0]  bea;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic        ceb, wrb;
    logic [1:0]  beb;
    logic [9:0]  addrb;
    logic [15:0] dinb;
    logic [15:0] ea, eb;
    logic        ec;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic ca, input logic wa, input logic [1:0] ba, input logic [9:0] aa,
                              input logic [15:0] da, input logic cb, input logic wb, input logic [1:0] bb,
                              input logic [9:0] ab, input logic [15:0] db, input logic [15:0] ea,
                              input logic [15:0] eb, input logic ec);
    vec_t v;
    v.cea = ca; v.wra = wa; v.bea = ba; v.addra = aa; v.dina = da;
    v.ceb = cb; v.wrb = wb; v.beb = bb; v.addrb = ab; v.dinb = db;
    v.ea = ea; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic port_a(input logic c, input logic w, input logic [1:0] b, input logic [9:0] a,
                        input logic [15:0] d);
    cea = c; wra = w; bea = b; addra = a; dina = d;
  endtask

  task automatic port_b(input logic c, input logic w, input logic [1:0] b, input logic [9:0] a,
                        input logic [15:0] d);
    ceb = c; wrb = w; beb = b; addrb = a; dinb = d;
  endtask

  task automatic idle();
    port_a(1'b0, 1'b0, 2'b00, 10'd0, 16'h0);
    port_b(1'b0, 1'b0, 2'b00, 10'd0, 16'h0);
  endtask

  initial begin
    logic [15:0] prev_a, prev_b;
`ifdef DP_BSRAM_INIT_CLEAR_EN
    int errs, cnt0, cnt4;
    logic col_busy;
`endif

    // Directed vectors against instance u0 (WRITE_MODE=0, READ_MODE=0)
    tbl[0]  = mk(1,1,2'b11,10'd5,   16'h1234, 0,0,2'b00,10'd0,   16'h0000, 16'h0000, 16'h0000, 0);
    tbl[1]  = mk(1,1,2'b01,10'd5,   16'hABCD, 0,0,2'b00,10'd0,   16'h0000, 16'h0000, 16'h0000, 0);
    tbl[2]  = mk(1,0,2'b00,10'd5,   16'h0000, 0,0,2'b00,10'd0,   16'h0000, 16'h12CD, 16'h0000, 0);
    tbl[3]  = mk(1,1,2'b11,10'd1023,16'h00FF, 0,0,2'b00,10'd0,   16'h0000, 16'h12CD, 16'h0000, 0);
    tbl[4]  = mk(0,0,2'b00,10'd0,   16'h0000, 1,0,2'b00,10'd1023,16'h0000, 16'h12CD, 16'h00FF, 0);
    tbl[5]  = mk(1,1,2'b01,10'd7,   16'h1111, 1,1,2'b11,10'd7,   16'h2222, 16'h12CD, 16'h00FF, 1);
    tbl[6]  = mk(1,0,2'b00,10'd7,   16'h0000, 0,0,2'b00,10'd0,   16'h0000, 16'h2211, 16'h00FF, 0);
    tbl[7]  = mk(1,1,2'b11,10'd9,   16'h5555, 0,0,2'b00,10'd0,   16'h0000, 16'h2211, 16'h00FF, 0);
    tbl[8]  = mk(1,1,2'b11,10'd9,   16'hAAAA, 1,0,2'b00,10'd9,   16'h0000, 16'h2211, 16'h5555, 1);
    tbl[9]  = mk(0,0,2'b00,10'd0,   16'h0000, 1,0,2'b00,10'd9,   16'h0000, 16'h2211, 16'hAAAA, 0);
    tbl[10] = mk(1,0,2'b00,10'd9,   16'h0000, 1,0,2'b00,10'd9,   16'h0000, 16'hAAAA, 16'hAAAA, 0);
    tbl[11] = mk(1,1,2'b10,10'd9,   16'h3C3C, 1,0,2'b00,10'd9,   16'h0000, 16'hAAAA, 16'hAAAA, 1);
    tbl[12] = mk(1,0,2'b00,10'd9,   16'h0000, 1,1,2'b00,10'd9,   16'hFFFF, 16'h3CAA, 16'hAAAA, 1);
    tbl[13] = mk(0,0,2'b00,10'd0,   16'h0000, 0,0,2'b00,10'd0,   16'h0000, 16'h3CAA, 16'hAAAA, 0);
    tbl[14] = mk(1,1,2'b11,10'd10,  16'h0A0A, 1,1,2'b11,10'd11,  16'h0B0B, 16'h3CAA, 16'hAAAA, 0);
    tbl[15] = mk(1,0,2'b00,10'd11,  16'h0000, 1,0,2'b00,10'd10,  16'h0000, 16'h0B0B, 16'h0A0A, 0);
    tbl[16] = mk(0,1,2'b11,10'd10,  16'hFFFF, 0,1,2'b11,10'd10,  16'hFFFF, 16'h0B0B, 16'h0A0A, 0);
    tbl[17] = mk(1,0,2'b00,10'd10,  16'h0000, 1,1,2'b00,10'd12,  16'h0000, 16'h0A0A, 16'h0A0A, 0);
    tbl[18] = mk(1,0,2'b00,10'd11,  16'h0000, 0,1,2'b11,10'd11,  16'h5A5A, 16'h0B0B, 16'h0A0A, 0);
    tbl[19] = mk(0,0,2'b00,10'd0,   16'h0000, 1,0,2'b00,10'd9,   16'h0000, 16'h0B0B, 16'h3CAA, 0);

    ocea = 1'b1;
    oceb = 1'b1;
    idle();
    reset = 1'b1;
    step();
    step();
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset_douta_u%0d", k), {16'h0, douta_w[k]}, 32'h0);
      check($sformatf("reset_doutb_u%0d", k), {16'h0, doutb_w[k]}, 32'h0);
      check($sformatf("reset_col_u%0d", k), {31'h0, col_w[k]}, 32'h0);
    end
    reset = 1'b0;

`ifdef DP_BSRAM_INIT_CLEAR_EN
    // Let the sweep run 500 cycles, then restart it with a reset pulse.
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      if (busy_w[0] !== 1'b1) errs++;
      if (i == 499) port_a(1'b1, 1'b0, 2'b00, 10'd0, 16'h0);
      step();
    end
    check("busy_first_500", errs, 0);
    check("clear_read_holds_0", {16'h0, douta_w[0]}, 32'h0);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt0 = 0;
    cnt4 = 0;
    col_busy = 1'b0;
    while ((busy_w[0] === 1'b1 || busy_w[4] === 1'b1) && cnt0 < 3000) begin
      if (busy_w[0] === 1'b1) cnt0++;
      if (busy_w[4] === 1'b1) cnt4++;
      if (cnt0 == 10) begin
        port_a(1'b1, 1'b1, 2'b11, 10'd3, 16'h5A5A);
        port_b(1'b1, 1'b1, 2'b11, 10'd3, 16'hA5A5);
      end else begin
        idle();
      end
      step();
      if (cnt0 == 10) col_busy = col_w[0];
    end
    idle();
    check("busy_cycles_1024", cnt0, 1024);
    check("busy_cycles_depth1000", cnt4, 1000);
    check("col_during_busy", {31'h0, col_busy}, 32'h0);
    errs = 0;
    for (int a = 0; a < 1024; a++) begin
      port_a(1'b1, 1'b0, 2'b00, 10'(a), 16'h0);
      step();
      if (douta_w[0] !== 16'h0) errs++;
    end
    idle();
    check("all_zero_after_clear", errs, 0);
`else
    check("busy_tied_low", {31'h0, busy_w[0]}, 32'h0);
`endif

    // Table: u0 sees latency 1; u3 (pipelined, oce held high) lags it by exactly one row.
    prev_a = douta_w[0];
    prev_b = doutb_w[0];
    for (int i = 0; i < 20; i++) begin
      port_a(tbl[i].cea, tbl[i].wra, tbl[i].bea, tbl[i].addra, tbl[i].dina);
      port_b(tbl[i].ceb, tbl[i].wrb, tbl[i].beb, tbl[i].addrb, tbl[i].dinb);
      step();
      check($sformatf("v%0d_douta", i), {16'h0, douta_w[0]}, {16'h0, tbl[i].ea});
      check($sformatf("v%0d_doutb", i), {16'h0, doutb_w[0]}, {16'h0, tbl[i].eb});
      check($sformatf("v%0d_col", i), {31'h0, col_w[0]}, {31'h0, tbl[i].ec});
      check($sformatf("v%0d_pipe_douta", i), {16'h0, douta_w[3]}, {16'h0, prev_a});
      check($sformatf("v%0d_pipe_doutb", i), {16'h0, doutb_w[3]}, {16'h0, prev_b});
      prev_a = tbl[i].ea;
      prev_b = tbl[i].eb;
    end
    idle();

    // Write modes: mem[5] currently 0x12CD
    port_a(1'b1, 1'b1, 2'b11, 10'd5, 16'h1234);
    step();
    check("wm1_full_write", {16'h0, douta_w[1]}, 32'h1234);
    check("wm2_old_word", {16'h0, douta_w[2]}, 32'h12CD);
    check("wm0_holds", {16'h0, douta_w[0]}, 32'h0B0B);
    port_a(1'b1, 1'b1, 2'b01, 10'd5, 16'hABCD);
    step();
    check("wm1_merged", {16'h0, douta_w[1]}, 32'h12CD);
    check("wm2_old_word2", {16'h0, douta_w[2]}, 32'h1234);
    idle();

    // Pipelined read latency and oceb hold on u3
    port_b(1'b1, 1'b0, 2'b00, 10'd7, 16'h0);
    step();
    port_b(1'b1, 1'b0, 2'b00, 10'd1023, 16'h0);
    step();
    check("rm0_lat1", {16'h0, doutb_w[0]}, 32'h00FF);
    check("rm1_not_yet", {16'h0, doutb_w[3]}, 32'h2211);
    check("oor_read_depth1000", {16'h0, doutb_w[4]}, 32'h0);
    idle();
    step();
    check("rm1_lat2", {16'h0, doutb_w[3]}, 32'h00FF);
    oceb = 1'b0;
    port_b(1'b1, 1'b0, 2'b00, 10'd5, 16'h0);
    step();
    check("rm1_oce0_hold1", {16'h0, doutb_w[3]}, 32'h00FF);
    idle();
    step();
    check("rm1_oce0_hold2", {16'h0, doutb_w[3]}, 32'h00FF);
    oceb = 1'b1;
    step();
    check("rm1_oce_reopen", {16'h0, doutb_w[3]}, 32'h12CD);

    // Out-of-range address on the DEPTH=1000 instance
    port_a(1'b1, 1'b1, 2'b11, 10'd1010, 16'hBEEF);
    port_b(1'b1, 1'b1, 2'b11, 10'd1010, 16'hBEEF);
    step();
    check("oor_no_collision", {31'h0, col_w[4]}, 32'h0);
    check("inrange_collision", {31'h0, col_w[0]}, 32'h1);
    idle();
    port_a(1'b1, 1'b0, 2'b00, 10'd1010, 16'h0);
    step();
    check("oor_read_zero", {16'h0, douta_w[4]}, 32'h0);
    check("inrange_read_1010", {16'h0, douta_w[0]}, 32'hBEEF);

    // Reset mid-burst: same-cycle write dropped, prior contents kept
    port_a(1'b1, 1'b1, 2'b11, 10'd30, 16'h7777);
    port_b(1'b1, 1'b1, 2'b11, 10'd31, 16'h1357);
    step();
    port_a(1'b1, 1'b1, 2'b11, 10'd30, 16'h8888);
    port_b(1'b1, 1'b1, 2'b11, 10'd31, 16'h2468);
    reset = 1'b1;
    step();
    check("midreset_douta", {16'h0, douta_w[0]}, 32'h0);
    check("midreset_doutb", {16'h0, doutb_w[0]}, 32'h0);
    check("midreset_pipe_douta", {16'h0, douta_w[3]}, 32'h0);
    reset = 1'b0;
    idle();
`ifdef DP_BSRAM_INIT_CLEAR_EN
    cnt0 = 0;
    while (busy_w[0] === 1'b1 && cnt0 < 3000) begin
      cnt0++;
      step();
    end
    check("post_reset_sweep_len", cnt0, 1024);
`endif
    port_a(1'b1, 1'b0, 2'b00, 10'd30, 16'h0);
    port_b(1'b1, 1'b0, 2'b00, 10'd31, 16'h0);
    step();
`ifdef DP_BSRAM_INIT_CLEAR_EN
    check("after_reset_a", {16'h0, douta_w[0]}, 32'h0);
    check("after_reset_b", {16'h0, doutb_w[0]}, 32'h0);
`else
    check("after_reset_a", {16'h0, douta_w[0]}, 32'h7777);
    check("after_reset_b", {16'h0, doutb_w[0]}, 32'h1357);
`endif
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_bsram_param.md
Name: dp_bsram_param

Overview:
- Generalised true dual-port block RAM for SR-1 memory subsystems; next generation of the fixed 1024x16 dual-port BSRAM wrapper.
- Parametrised in width, depth and address size, with byte-lane write enables.
- Selectable write mode and optional output pipeline register per port.
- Defined collision arbitration with a collision flag.
- Single clock domain; both ports share the clock.

Parameters:
- A_SIZE, 10, address width.
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**A_SIZE.
- W_SIZE, 16, data width; must be a multiple of 8.
- WRITE_MODE, 0, read-register behaviour on write. 0 = normal (hold), 1 = write-through, 2 = read-before-write.
- READ_MODE, 0, output pipelining. 0 = bypass (latency 1), 1 = pipelined through the oce register (latency 2).

Ports:
- clk  in  1  clock; both ports sample on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cea, ceb  in  1  port A/B clock enable.
- ocea, oceb  in  1  port A/B output register enable; used only when READ_MODE=1.
- wra, wrb  in  1  port A/B write enable; 0 = read.
- bea, beb  in  W_SIZE/8  port A/B byte-lane write enables.
- addra, addrb  in  A_SIZE  port A/B address.
- dina, dinb  in  W_SIZE  port A/B write data.
- douta, doutb  out  W_SIZE  port A/B read data.
- collision  out  1  one-cycle pulse on an address collision.
- busy  out  1  init-clear in progress; constant 0 without the feature.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset effects: read registers ra/rb, output registers oa/ob and collision go to 0. douta = doutb = 0 from the first edge with reset=1. Memory contents are retained.
- Reset priority: reset overrides everything, and any write presented in the same cycle as reset is dropped.
- Write: at an edge with ce=1 and wr=1, mem[addr] lane i <= din lane i for every i with be[i]=1. Other lanes are unchanged. be=0 writes nothing but still counts as a write for mode and collision purposes.
- Read: at an edge with ce=1 and wr=0, r <= mem[addr].
- Read register on a write cycle, by WRITE_MODE:
  - 0: r holds.
  - 1: r <= merged new word (din on enabled lanes, old data elsewhere).
  - 2: r <= old word.
- Port idle: ce=0 means r and the memory are untouched for that port.
- READ_MODE=0: dout = r; read latency is 1 cycle.
- READ_MODE=1: o <= r at an edge where oce=1, otherwise o holds. dout = o; latency is 2 cycles with oce held high.
- Out-of-range address (addr >= DEPTH): the write is ignored and the read loads 0. collision is not evaluated for that port.
- Collision condition: cea=ceb=1, addra==addrb (in range), and at least one port writes. collision is registered high for exactly the next cycle; back-to-back collisions keep it high.
- Both ports write: port A wins on lanes where bea=1. Port B's lanes with beb=1 and bea=0 are still written.
- One port writes, the other reads: the reading port gets the old word, whatever WRITE_MODE is. The writing port follows its WRITE_MODE.
- Both ports read the same address: no collision; both get the data.

Optional Feature:
- Macro: DP_BSRAM_INIT_CLEAR_EN.
- Defined: an FSM with states IDLE and CLEAR. Reset forces CLEAR with the pointer at 0. After reset falls, the FSM writes 0 to mem[ptr] and increments ptr each cycle, DEPTH cycles in total, then goes to IDLE.
- Defined, during CLEAR: busy=1, all port writes are dropped, read registers hold 0, and collision is 0. Asserting reset during CLEAR restarts the sweep at 0.
- Not defined: no FSM, busy tied 0, memory powers up uninitialised (X in simulation).

Test Plan (defaults unless noted):
1. Byte lanes, write modes: A writes 0x1234 to addr 5 (bea=11), then writes 0xABCD with bea=01 → A reads 0x12CD at addr 5. Repeat with WRITE_MODE=1: douta=0x12CD in the write cycle +1. With WRITE_MODE=2: douta=0x1234 in the write cycle +1.
2. Cross-port latency: A writes 0x00FF to addr 1023; B reads addr 1023 → doutb=0x00FF one cycle after the read edge. With READ_MODE=1 and oceb=1, doutb=0x00FF two cycles after. With oceb=0, doutb holds its previous value.
3. Write-write collision: both ports write addr 7 in the same cycle, A=0x1111 bea=01, B=0x2222 beb=11 → mem[7]=0x2211, and collision=1 for exactly one cycle.
4. Read-write collision: mem[9]=0x5555; A writes 0xAAAA to addr 9 while B reads addr 9 → doutb=0x5555, collision pulses, and a later B read returns 0xAAAA.
5. Reset and out-of-range: with DEPTH=1000, a write to addr 1010 then a read → dout=0 and mem unchanged. Assert reset mid-burst → douta=doutb=0 next cycle, the same-cycle write is dropped, and prior contents survive.
6. With DP_BSRAM_INIT_CLEAR_EN: busy=1 for 1024 cycles after reset falls, and a write issued during busy is lost. Afterwards every address reads 0. Reset at sweep cycle 500 → busy lasts 1024 more cycles.
